// File: rtl/interrupt_sequencer.sv
// Interrupt entry/return sequencer driving the register file's backup, return-address and flag ports.
// Define IRQ_MASK_EN to add a software-writable per-source mask (mask_input/mask_write).
module interrupt_sequencer #(
    parameter logic [15:0] VECTOR_BASE   = 16'h0010,
    parameter logic [15:0] VECTOR_STRIDE = 16'h0004
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef IRQ_MASK_EN
    input  logic [8:0]  mask_input,
    input  logic        mask_write,
`endif
    input  logic [8:0]  irq_request,
    input  logic        global_enable,
    input  logic        insn_boundary,
    input  logic [15:0] current_pc,
    input  logic        reti_req,
    input  logic [15:0] return_address_output,
    output logic        r_backup,
    output logic        r_restore,
    output logic [15:0] return_address_input,
    output logic        return_address_write,
    output logic [8:0]  interrupt_input,
    output logic        interrupt_write,
    output logic        vector_valid,
    output logic [15:0] vector_addr,
    output logic        return_valid,
    output logic [15:0] return_pc,
    output logic        in_isr
);

    typedef enum logic [2:0] {
        IDLE, BACKUP, SAVE_RA, VECTOR, ISR, RESTORE, RETURN
    } state_t;

    state_t      state_reg, state_next;
    logic [8:0]  pending_reg, pending_next;
    logic [8:0]  clear_mask;
    logic [8:0]  eligible;
    logic [3:0]  active_idx_reg, active_idx_next, lowest_idx;
    logic [15:0] saved_pc_reg, saved_pc_next;

`ifdef IRQ_MASK_EN
    logic [8:0] mask_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mask_reg <= 9'h1FF;
        else if (mask_write)
            mask_reg <= mask_input;
    end

    // Masked sources still latch into pending; they are only excluded from selection.
    assign eligible = pending_reg & mask_reg;
`else
    assign eligible = pending_reg;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_clear
            assign clear_mask[gi] = (state_reg == RESTORE) && (active_idx_reg == 4'(gi));
        end
    endgenerate

    // New requests are OR-ed in after the clear so a same-cycle re-request survives.
    assign pending_next = (pending_reg & ~clear_mask) | irq_request;

    always_comb begin
        lowest_idx = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (eligible[i])
                lowest_idx = 4'(i);
        end
    end

    always_comb begin
        state_next      = state_reg;
        active_idx_next = active_idx_reg;
        saved_pc_next   = saved_pc_reg;
        case (state_reg)
            IDLE: begin
                if (global_enable && insn_boundary && (eligible != 9'd0)) begin
                    state_next      = BACKUP;
                    active_idx_next = lowest_idx;
                    saved_pc_next   = current_pc;
                end
            end
            BACKUP:  state_next = SAVE_RA;
            SAVE_RA: state_next = VECTOR;
            VECTOR:  state_next = ISR;
            ISR: begin
                if (reti_req)
                    state_next = RESTORE;
            end
            RESTORE: state_next = RETURN;
            RETURN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            pending_reg    <= 9'd0;
            active_idx_reg <= 4'd0;
            saved_pc_reg   <= 16'd0;
        end else begin
            state_reg      <= state_next;
            pending_reg    <= pending_next;
            active_idx_reg <= active_idx_next;
            saved_pc_reg   <= saved_pc_next;
        end
    end

    // Outputs are registered from the next state so each strobe lines up with its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_backup             <= 1'b0;
            r_restore            <= 1'b0;
            return_address_input <= 16'd0;
            return_address_write <= 1'b0;
            interrupt_input      <= 9'd0;
            interrupt_write      <= 1'b0;
            vector_valid         <= 1'b0;
            vector_addr          <= 16'd0;
            return_valid         <= 1'b0;
            return_pc            <= 16'd0;
            in_isr               <= 1'b0;
        end else begin
            r_backup             <= (state_next == BACKUP);
            r_restore            <= (state_next == RESTORE);
            return_address_write <= (state_next == SAVE_RA);
            vector_valid         <= (state_next == VECTOR);
            return_valid         <= (state_next == RETURN);
            in_isr               <= (state_next != IDLE) && (state_next != RETURN);
            interrupt_input      <= pending_next;
            interrupt_write      <= (pending_next != pending_reg);
            if (state_next == SAVE_RA)
                return_address_input <= saved_pc_reg;
            if (state_next == VECTOR)
                vector_addr <= VECTOR_BASE + VECTOR_STRIDE * {12'd0, active_idx_reg};
            if (state_next == RETURN)
                return_pc <= return_address_output;
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: timeline model checked every cycle plus directed literal checks.
// Build with IRQ_MASK_EN defined to exercise the mask variant as well.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  irq_request = 9'd0;
    logic        global_enable = 1'b0;
    logic        insn_boundary = 1'b0;
    logic [15:0] current_pc = 16'd0;
    logic        reti_req = 1'b0;
    logic [15:0] return_address_output = 16'd0;
    logic        r_backup, r_restore, return_address_write, interrupt_write;
    logic        vector_valid, return_valid, in_isr;
    logic [15:0] return_address_input, vector_addr, return_pc;
    logic [8:0]  interrupt_input;
`ifdef IRQ_MASK_EN
    logic [8:0]  mask_input = 9'h1FF;
    logic        mask_write = 1'b0;
`endif

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    interrupt_sequencer dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
`ifdef IRQ_MASK_EN
        .mask_input            (mask_input),
        .mask_write            (mask_write),
`endif
        .irq_request           (irq_request),
        .global_enable         (global_enable),
        .insn_boundary         (insn_boundary),
        .current_pc            (current_pc),
        .reti_req              (reti_req),
        .return_address_output (return_address_output),
        .r_backup              (r_backup),
        .r_restore             (r_restore),
        .return_address_input  (return_address_input),
        .return_address_write  (return_address_write),
        .interrupt_input       (interrupt_input),
        .interrupt_write       (interrupt_write),
        .vector_valid          (vector_valid),
        .vector_addr           (vector_addr),
        .return_valid          (return_valid),
        .return_pc             (return_pc),
        .in_isr                (in_isr)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lowest_bit(input logic [8:0] v);
        for (int i = 0; i < 9; i++)
            if (v[i]) return i;
        return 0;
    endfunction

    // Timeline model: each sequence is described by the edge that accepted it and the
    // edge that accepted reti; every strobe is a fixed offset from one of those edges.
    int          e;
    int          acc_e, reti_e, m_idx;
    logic [8:0]  m_pending, m_mask;
    logic [15:0] m_pc, m_rpc;
    logic        exp_iw;

    always @(posedge clk) begin
        logic [8:0] old_p, clr;
        bit busy;
        if (!rst_n) begin
            e = 0; acc_e = -1; reti_e = -1; m_idx = 0;
            m_pending = 9'd0; m_mask = 9'h1FF; m_pc = 16'd0; m_rpc = 16'd0; exp_iw = 1'b0;
        end else begin
            old_p = m_pending;
            clr = (reti_e >= 0 && e == reti_e + 1) ? (9'd1 << m_idx) : 9'd0;
            busy = (acc_e >= 0) && (reti_e < 0 || e <= reti_e + 2);
            if (!busy && global_enable && insn_boundary && ((old_p & m_mask) != 9'd0)) begin
                acc_e = e; reti_e = -1; m_idx = lowest_bit(old_p & m_mask); m_pc = current_pc;
            end else if (acc_e >= 0 && reti_e < 0 && e >= acc_e + 4 && reti_req) begin
                reti_e = e;
            end
            m_pending = (old_p & ~clr) | irq_request;
            exp_iw = (m_pending != old_p);
            if (reti_e >= 0 && e == reti_e + 1)
                m_rpc = return_address_output;
`ifdef IRQ_MASK_EN
            if (mask_write) m_mask = mask_input;
`endif
        end
        #1;
        begin
            bit a, r;
            a = (acc_e >= 0) && rst_n;
            r = (reti_e >= 0) && rst_n;
            check("m_r_backup", 16'(r_backup), 16'(a && e == acc_e));
            check("m_ra_write", 16'(return_address_write), 16'(a && e == acc_e + 1));
            check("m_vector_valid", 16'(vector_valid), 16'(a && e == acc_e + 2));
            check("m_r_restore", 16'(r_restore), 16'(r && e == reti_e));
            check("m_return_valid", 16'(return_valid), 16'(r && e == reti_e + 1));
            check("m_in_isr", 16'(in_isr), 16'(a && e >= acc_e && (reti_e < 0 || e <= reti_e)));
            check("m_irq_input", 16'(interrupt_input), 16'(m_pending));
            check("m_irq_write", 16'(interrupt_write), 16'(exp_iw));
            if (a && e == acc_e + 1)
                check("m_ra_data", return_address_input, m_pc);
            if (a && e == acc_e + 2)
                check("m_vector_addr", vector_addr, 16'h0010 + 16'(m_idx * 4));
            if (r && e == reti_e + 1)
                check("m_return_pc", return_pc, m_rpc);
        end
        if (rst_n) e++;
    end

    // One full entry/return with literal expectations; irq_rs is driven in the RESTORE cycle.
    task automatic do_seq(input logic [15:0] pc, input logic [8:0] irq_rs, input logic [15:0] exp_vec);
        @(negedge clk); global_enable = 1'b1; insn_boundary = 1'b1; current_pc = pc;
        @(negedge clk); global_enable = 1'b0; insn_boundary = 1'b0;
        check("seq_r_backup", 16'(r_backup), 16'd1);
        @(negedge clk);
        check("seq_ra_write", 16'(return_address_write), 16'd1);
        check("seq_ra_data", return_address_input, pc);
        @(negedge clk);
        check("seq_vector_valid", 16'(vector_valid), 16'd1);
        check("seq_vector_addr", vector_addr, exp_vec);
        @(negedge clk);
        check("seq_in_isr", 16'(in_isr), 16'd1);
        return_address_output = pc; reti_req = 1'b1;
        @(negedge clk); reti_req = 1'b0; irq_request = irq_rs;
        check("seq_r_restore", 16'(r_restore), 16'd1);
        @(negedge clk); irq_request = 9'd0;
        check("seq_return_valid", 16'(return_valid), 16'd1);
        check("seq_return_pc", return_pc, pc);
        check("seq_in_isr_off", 16'(in_isr), 16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        irq_request = 9'h004;
        repeat (3) @(negedge clk);
        check("rst_irq_input", 16'(interrupt_input), 16'd0);
        check("rst_irq_write", 16'(interrupt_write), 16'd0);
        check("rst_strobes", 16'({r_backup, r_restore, return_address_write, vector_valid, return_valid, in_isr}), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_irq_write", 16'(interrupt_write), 16'd1);
        check("rel_irq_input", 16'(interrupt_input), 16'h004);
        @(negedge clk);
        check("rel_irq_write_once", 16'(interrupt_write), 16'd0);

        // pending becomes 0x024; disabled interrupts and stray reti must do nothing
        irq_request = 9'h020;
        @(negedge clk); irq_request = 9'd0; insn_boundary = 1'b1; reti_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("dis_r_backup", 16'(r_backup), 16'd0);
            check("idle_r_restore", 16'(r_restore), 16'd0);
            check("idle_return_valid", 16'(return_valid), 16'd0);
        end
        insn_boundary = 1'b0; reti_req = 1'b0;
        check("pend_024", 16'(interrupt_input), 16'h024);

        do_seq(16'h0123, 9'd0, 16'h0018);
        check("pend_after_clear", 16'(interrupt_input), 16'h020);

        // re-raise bit 2, then re-request it during RESTORE: set must win over clear
        irq_request = 9'h004;
        @(negedge clk); irq_request = 9'd0;
        do_seq(16'h0456, 9'h004, 16'h0018);
        check("set_wins", 16'(interrupt_input), 16'h024);
        do_seq(16'h0789, 9'd0, 16'h0018);
        // accepted in the first cycle after RETURN
        do_seq(16'h0AAA, 9'd0, 16'h0024);
        check("pend_empty", 16'(interrupt_input), 16'h000);

        // reset while in BACKUP: the return-address strobe must never appear
        irq_request = 9'h001;
        @(negedge clk); irq_request = 9'd0; global_enable = 1'b1; insn_boundary = 1'b1;
        @(negedge clk); global_enable = 1'b0; insn_boundary = 1'b0;
        check("abort_r_backup", 16'(r_backup), 16'd1);
        rst_n = 1'b0;
        #1 check("abort_cleared", 16'({r_backup, in_isr}), 16'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_ra_write", 16'(return_address_write), 16'd0);
            check("abort_in_isr", 16'(in_isr), 16'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_vector", 16'(vector_valid), 16'd0);

`ifdef IRQ_MASK_EN
        mask_input = 9'h1FB; mask_write = 1'b1; irq_request = 9'h024;
        @(negedge clk); mask_write = 1'b0; irq_request = 9'd0;
        do_seq(16'h0321, 9'd0, 16'h0024);
        check("mask_pend", 16'(interrupt_input), 16'h004);
        global_enable = 1'b1; insn_boundary = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("mask_blocks", 16'(r_backup), 16'd0);
        end
        global_enable = 1'b0; insn_boundary = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
